// File: rtl/lm_sm_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// lm_sm_sequencer_pkg
//   Shared definitions for the LM/SM multi-register transfer sequencer:
//   opcode encodings, FSM state encoding and small combinational helpers.
//   The opcode list must stay consistent with the forwarding units'
//   parameter sets.
// ---------------------------------------------------------------------------
package lm_sm_sequencer_pkg;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_DONE = 2'b10
    } seq_state_e;

    // True for the two opcodes this sequencer expands.
    function automatic logic is_lm_sm(input logic [3:0] op);
        return (op == OP_LM) || (op == OP_SM);
    endfunction

    // Clear the lowest set bit of a register list (the one just transferred).
    function automatic logic [7:0] clear_lowest(input logic [7:0] m);
        return m & (m - 8'd1);
    endfunction

endpackage

// File: rtl/lm_sm_sequencer_lowest_set_bit8.sv
// ---------------------------------------------------------------------------
// lowest_set_bit8
//   Combinational 8->3 priority encoder; the least significant set bit wins.
//   Ports:
//     mask   in  8  register list
//     idx    out 3  index of the lowest set bit (0 when mask is empty)
//     valid  out 1  mask has at least one bit set
// ---------------------------------------------------------------------------
module lowest_set_bit8 (
    input  logic [7:0] mask,
    output logic [2:0] idx,
    output logic       valid
);

    // LSB-first priority encode of the register list.
    always_comb begin
        idx   = 3'd0;
        valid = |mask;
        casez (mask)
            8'b???????1: idx = 3'd0;
            8'b??????10: idx = 3'd1;
            8'b?????100: idx = 3'd2;
            8'b????1000: idx = 3'd3;
            8'b???10000: idx = 3'd4;
            8'b??100000: idx = 3'd5;
            8'b?1000000: idx = 3'd6;
            8'b10000000: idx = 3'd7;
            default:     idx = 3'd0;
        endcase
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// ---------------------------------------------------------------------------
// lm_sm_sequencer
//   Expands one LM/SM instruction into one data-memory access per set bit of
//   its register list, lowest register first, at consecutive addresses from
//   the base held in regA. Stalls the front of the pipeline while transfers
//   are in progress. All outputs are decoded from registered state only.
//   Ports:
//     clk        in   1   clock, rising edge
//     rst_n      in   1   asynchronous active-low reset
//     start      in   1   decode-stage instruction valid
//     ir_in      in   16  instruction: [15:12] opcode, [7:0] register list
//     base_addr  in   AW  base address (regA, already forwarded)
//     flush      in   1   squash; aborts a sequence in progress
//     busy       out  1   sequence active (XFER or DONE)
//     stall      out  1   hold IF/ID, insert bubble (XFER)
//     mem_addr   out  AW  data-memory address of the current transfer
//     mem_we     out  1   SM transfer: write RF[reg_sel] to memory
//     rf_we      out  1   LM transfer: write memory read data to RF[reg_sel]
//     reg_sel    out  3   register index of the current transfer
//     done       out  1   one-cycle completion pulse
// ---------------------------------------------------------------------------
module lm_sm_sequencer
    import lm_sm_sequencer_pkg::*;
#(
    parameter int AW    = 16,
    parameter int NREGS = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   ir_in,
    input  logic [AW-1:0] base_addr,
    input  logic          flush,
    output logic          busy,
    output logic          stall,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          rf_we,
    output logic [2:0]    reg_sel,
    output logic          done
);

    seq_state_e       state_r;
    seq_state_e       state_next_s;
    logic [NREGS-1:0] mask_r;
    logic [AW-1:0]    base_r;
    logic             is_load_r;
    // 3-bit transfer count plus carry; zero-extended before the address add.
    logic [3:0]       offset_r;

    logic [2:0]       low_idx_s;
    logic             low_valid_s;
    logic [7:0]       mask_after_s;
    logic             accept_s;

    logic             busy_s;
    logic             stall_s;
    logic [AW-1:0]    mem_addr_s;
    logic             mem_we_s;
    logic             rf_we_s;
    logic [2:0]       reg_sel_s;
    logic             done_s;

    // Opcode-independent instruction bits are not needed here.
    logic             unused_ir_s;
    assign unused_ir_s = ^{ir_in[11:8], low_valid_s};

    lowest_set_bit8 u_lsb (
        .mask  (mask_r),
        .idx   (low_idx_s),
        .valid (low_valid_s)
    );

    assign mask_after_s = clear_lowest(mask_r);
    assign accept_s     = start && is_lm_sm(ir_in[15:12]);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; flush wins over completion of the last transfer.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = (ir_in[7:0] != 8'd0) ? ST_XFER : ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else if (mask_after_s == 8'd0) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_XFER;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Sequence context: list, base, direction and transfer offset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r    <= 8'd0;
            base_r    <= {AW{1'b0}};
            is_load_r <= 1'b0;
            offset_r  <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        mask_r    <= ir_in[7:0];
                        base_r    <= base_addr;
                        is_load_r <= (ir_in[15:12] == OP_LM);
                        offset_r  <= 4'd0;
                    end else begin
                        mask_r    <= mask_r;
                        base_r    <= base_r;
                        is_load_r <= is_load_r;
                        offset_r  <= offset_r;
                    end
                end
                ST_XFER: begin
                    if (flush) begin
                        mask_r   <= 8'd0;
                        offset_r <= 4'd0;
                    end else begin
                        mask_r   <= mask_after_s;
                        offset_r <= offset_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    mask_r   <= 8'd0;
                    offset_r <= 4'd0;
                end
                default: begin
                    mask_r   <= 8'd0;
                    offset_r <= 4'd0;
                end
            endcase
        end
    end

    // Moore output decode from registered state only.
    always_comb begin
        busy_s     = 1'b0;
        stall_s    = 1'b0;
        mem_addr_s = {AW{1'b0}};
        mem_we_s   = 1'b0;
        rf_we_s    = 1'b0;
        reg_sel_s  = 3'd0;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_XFER: begin
                busy_s     = 1'b1;
                stall_s    = 1'b1;
                // Address wraps modulo 2**AW by truncation of the sum.
                mem_addr_s = base_r + {{(AW-4){1'b0}}, offset_r};
                mem_we_s   = !is_load_r;
                rf_we_s    = is_load_r;
                reg_sel_s  = low_idx_s;
            end
            ST_DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign busy     = busy_s;
    assign stall    = stall_s;
    assign mem_addr = mem_addr_s;
    assign mem_we   = mem_we_s;
    assign rf_we    = rf_we_s;
    assign reg_sel  = reg_sel_s;
    assign done     = done_s;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lm_sm_sequencer
//   Self-checking bench: directed scenarios followed by randomized traffic,
//   compared every cycle against a queue-based transaction model.
// ---------------------------------------------------------------------------
module tb_lm_sm_sequencer;

    localparam logic [3:0] LM  = 4'b0110;
    localparam logic [3:0] SM  = 4'b0111;
    localparam logic [3:0] ADD = 4'b0000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] ir_in;
    logic [15:0] base_addr;
    logic        flush;
    logic        busy;
    logic        stall;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic        rf_we;
    logic [2:0]  reg_sel;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: pending transfers (register, address), pending done, direction.
    int          m_reg_q[$];
    logic [15:0] m_addr_q[$];
    bit          m_done_pend = 1'b0;
    bit          m_load      = 1'b0;

    lm_sm_sequencer #(.AW(16), .NREGS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ir_in     (ir_in),
        .base_addr (base_addr),
        .flush     (flush),
        .busy      (busy),
        .stall     (stall),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .rf_we     (rf_we),
        .reg_sel   (reg_sel),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_reg_q.delete();
        m_addr_q.delete();
        m_done_pend = 1'b0;
    endtask

    // Compare all outputs with what the model says this cycle should show.
    task automatic check_outputs();
        logic        e_busy, e_stall, e_mwe, e_rwe, e_done;
        logic [15:0] e_addr;
        logic [2:0]  e_reg;
        e_busy = 1'b0; e_stall = 1'b0; e_mwe = 1'b0; e_rwe = 1'b0;
        e_done = 1'b0; e_addr = 16'h0000; e_reg = 3'd0;
        if (m_reg_q.size() > 0) begin
            e_busy  = 1'b1;
            e_stall = 1'b1;
            e_addr  = m_addr_q[0];
            e_reg   = 3'(m_reg_q[0]);
            e_rwe   = m_load;
            e_mwe   = !m_load;
        end else if (m_done_pend) begin
            e_busy = 1'b1;
            e_done = 1'b1;
        end
        check_val("busy",     32'(busy),     32'(e_busy));
        check_val("stall",    32'(stall),    32'(e_stall));
        check_val("mem_addr", 32'(mem_addr), 32'(e_addr));
        check_val("mem_we",   32'(mem_we),   32'(e_mwe));
        check_val("rf_we",    32'(rf_we),    32'(e_rwe));
        check_val("reg_sel",  32'(reg_sel),  32'(e_reg));
        check_val("done",     32'(done),     32'(e_done));
    endtask

    // Model reaction to one clock edge with the given inputs.
    task automatic model_edge(input logic st, input logic [15:0] ir,
                              input logic [15:0] base, input logic fl);
        logic [15:0] a;
        if (m_reg_q.size() > 0) begin
            if (fl) begin
                model_clear();
            end else begin
                void'(m_reg_q.pop_front());
                void'(m_addr_q.pop_front());
            end
        end else if (m_done_pend) begin
            m_done_pend = 1'b0;
        end else if (st && (ir[15:12] == LM || ir[15:12] == SM)) begin
            m_load = (ir[15:12] == LM);
            a = base;
            for (int i = 0; i < 8; i++) begin
                if (ir[i]) begin
                    m_reg_q.push_back(i);
                    m_addr_q.push_back(a);
                    a = a + 16'd1;
                end
            end
            m_done_pend = 1'b1;
        end
    endtask

    // One cycle: check at negedge, drive inputs, advance model on posedge.
    task automatic step(input logic st, input logic [15:0] ir,
                        input logic [15:0] base, input logic fl);
        @(negedge clk);
        check_outputs();
        start     = st;
        ir_in     = ir;
        base_addr = base;
        flush     = fl;
        @(posedge clk);
        model_edge(st, ir, base, fl);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 16'h0000, 1'b0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [7:0]  lst;
        logic [15:0] b;
        rst_n = 1'b0; start = 1'b0; ir_in = 16'h0000;
        base_addr = 16'h0000; flush = 1'b0;
        #3;
        check_val("reset_busy",  32'(busy),  32'd0);
        check_val("reset_done",  32'(done),  32'd0);
        check_val("reset_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        // 1: LM two registers
        step(1'b1, {LM, 4'h0, 8'b0000_0101}, 16'h0040, 1'b0);
        idle_cycles(4);
        // 2: SM full list across address wrap
        step(1'b1, {SM, 4'h3, 8'hFF}, 16'hFFFE, 1'b0);
        idle_cycles(10);
        // 3: LM empty list
        step(1'b1, {LM, 4'h0, 8'h00}, 16'h1234, 1'b0);
        idle_cycles(3);
        // 4: start held high throughout
        for (int i = 0; i < 7; i++) step(1'b1, {SM, 4'h0, 8'b1000_0001}, 16'h0010, 1'b0);
        idle_cycles(4);
        // 5: flush in second XFER cycle
        step(1'b1, {LM, 4'h0, 8'hF0}, 16'h0200, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b1);
        idle_cycles(3);
        // 6: asynchronous reset mid-XFER
        step(1'b1, {LM, 4'h0, 8'hF0}, 16'h0300, 1'b0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0);
        #2;
        check_val("pre_rst_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst_busy",  32'(busy),  32'd0);
        check_val("rst_stall", 32'(stall), 32'd0);
        check_val("rst_rf_we", 32'(rf_we), 32'd0);
        check_val("rst_addr",  32'(mem_addr), 32'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        step(1'b1, {ADD, 4'h1, 8'hFF}, 16'h0400, 1'b0);
        idle_cycles(3);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0: op = LM;
                1: op = SM;
                2: op = ADD;
                default: op = 4'($urandom_range(0, 15));
            endcase
            case ($urandom_range(0, 3))
                0: lst = 8'h00;
                1: lst = 8'(1 << $urandom_range(0, 7));
                default: lst = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 3) == 0) b = 16'hFFF8 + 16'($urandom_range(0, 7));
            else b = 16'($urandom_range(0, 65535));
            step($urandom_range(0, 9) < 6, {op, 4'($urandom_range(0, 15)), lst},
                 b, $urandom_range(0, 15) == 0);
        end
        idle_cycles(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
